// File: rtl/ram_burst.sv
// ram_burst: single-port synchronous RAM (2^ADDR_W x DATA_W) driven by a burst command engine.
// Latency: read beats appear on Out one edge after the command edge, back-to-back; Done marks the last beat.
// Backpressure: none on reads; writes advance only on cycles where In_Valid is high while In_Ready is set.
//
// Ports:
//   Clk, Reset_n          - rising-edge clock, asynchronous active-low reset
//   Enable/RW/Address/Length - burst command, sampled only while idle (RW=1 read, Length=0 -> 2^LEN_W beats)
//   In/In_Valid/In_Ready  - write beat stream
//   Out/Out_Valid         - registered read beat stream
//   Busy, Done            - burst in progress, one-cycle completion pulse
module ram_burst #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Enable,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Address,
    input  logic [LEN_W-1:0]  Length,
    input  logic [DATA_W-1:0] In,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [DATA_W-1:0] Out,
    output logic              Out_Valid,
    output logic              Busy,
    output logic              Done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Storage array; not touched by reset so an aborted burst keeps what it wrote.
    logic [DATA_W-1:0] Mem [0:DEPTH-1];

    logic [ADDR_W-1:0] r_ptr;
    // One extra bit so a zero Length can hold the full 2^LEN_W beat count.
    logic [LEN_W:0]    r_cnt;

    logic              w_accept;
    logic              w_rd_beat;
    logic              w_wr_beat;
    logic              w_last;
    logic [LEN_W:0]    w_len;

    assign w_accept  = (r_state == IDLE) && Enable;
    assign w_rd_beat = (r_state == READ);
    assign w_wr_beat = (r_state == WRITE) && In_Valid;
    assign w_last    = (r_cnt == (LEN_W+1)'(1));
    assign w_len     = (Length == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, Length};

    assign Busy      = (r_state != IDLE);
    assign In_Ready  = (r_state == WRITE);

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (Enable) begin
                    w_next = RW ? READ : WRITE;
                end
            end
            READ: begin
                if (w_last) begin
                    w_next = IDLE;
                end
            end
            WRITE: begin
                if (In_Valid && w_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Pointer, counter and registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr     <= '0;
            r_cnt     <= '0;
            Out       <= '0;
            Out_Valid <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Out_Valid <= w_rd_beat;
            // Done lands in the cycle after the final beat edge: alongside the last
            // Out_Valid for reads, and in the first idle cycle for writes.
            Done      <= (w_rd_beat || w_wr_beat) && w_last;
            if (w_accept) begin
                r_ptr <= Address;
                r_cnt <= w_len;
            end else if (w_rd_beat || w_wr_beat) begin
                r_ptr <= r_ptr + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
                r_cnt <= r_cnt - (LEN_W+1)'(1);
            end
            if (w_rd_beat) begin
                Out <= Mem[r_ptr];
            end
        end
    end

    // Array write port
    always_ff @(posedge Clk) begin
        if (w_wr_beat) begin
            Mem[r_ptr] <= In;
        end
    end

endmodule
